seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N, default 4: digit width in bits; only 4 is supported (hex decode).
REQ-002 Parameter DIV, default 100000: SHOW-state dwell time, in clk cycles; legal range is 2 or more.
REQ-003 Parameter BLANK, default 2: dead-time dwell, in clk cycles; legal range is 1 or more.
REQ-004 clk  in  1  single system clock; all logic rises on its posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  scan enable; 0 blanks the display.
REQ-007 val_a  in  N  digit-0 value.
REQ-008 val_b  in  N  digit-1 value.
REQ-009 dp_in  in  2  decimal points; bit0 belongs to digit 0, bit1 to digit 1.
REQ-010 sel  out  1  digit select, driving the downstream 2:1 mux s input (0 = digit 0).
REQ-011 an  out  2  anode enables, active-low; bit0 drives digit 0.
REQ-012 seg  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
REQ-013 dp  out  1  decimal-point cathode, active-low.
REQ-014 frame  out  1  one-cycle pulse on SHOW_A entry.

Function
REQ-015 The FSM SHALL have four states, cycling SHOW_A -> BLANK_A -> SHOW_B -> BLANK_B -> SHOW_A.
REQ-016 The prescaler cnt SHALL count 0..DIV-1 in SHOW states and 0..BLANK-1 in BLANK states; on the terminal count the state advances and cnt returns to 0.
REQ-017 On every transition into SHOW_A, val_a, val_b and dp_in SHALL be snapshotted; displayed data SHALL change only at frame boundaries.
REQ-018 In SHOW_A: an=2'b10, sel=0, seg=hex(snap_a), dp=~snap_dp[0].
REQ-019 In SHOW_B: an=2'b01, sel=1, seg=hex(snap_b), dp=~snap_dp[1].
REQ-020 In BLANK states: an=2'b11, seg=7'h7F, dp=1; sel holds the value from the preceding SHOW state.
REQ-021 All outputs SHALL be registered and SHALL change on the same edge as the state register; there are no combinational paths from inputs to outputs.
REQ-022 The frame period SHALL be exactly 2*(DIV+BLANK) cycles while en=1.
REQ-023 en=0, sampled on any edge: the next state is BLANK_B with cnt=0, and outputs take blank values; en has priority over the terminal count.
REQ-024 After en returns to 1, SHOW_A SHALL be entered after exactly BLANK cycles, with a fresh snapshot and a frame pulse.
REQ-025 The hex decode SHALL use standard glyphs: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.
REQ-026 cnt SHALL be $clog2(DIV) bits wide (minimum 1); wrap-around beyond the terminal count SHALL never occur.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=BLANK_B, cnt=0, an=2'b11, seg=7'h7F, dp=1, sel=0, frame=0, all snapshots 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no partial digit shown; after release the sequence restarts per REQ-024.

Structure
REQ-029 The shared package SHALL hold the state enum (SHOW_A, BLANK_A, SHOW_B, BLANK_B) and the glyph constants SEG_BLANK=7'h7F and AN_OFF=2'b11.
REQ-030 The hex-to-7-segment decode SHALL be a separate combinational sub-module, hex7seg (4-bit in, 7-bit active-low out).

Verification (DIV=4, BLANK=2, frame=12 cycles)
REQ-031 Reset release with en=1, val_a=4'h1, val_b=4'hF -> an=11 for 2 cycles; then an=10 with seg=7'h79 for 4 cycles; 2 blank cycles; an=01 with seg=7'h0E for 4 cycles; frame pulses every 12 cycles.
REQ-032 Change val_a from 4'h0 to 4'h8 during SHOW_B -> seg stays 7'h40 until the next SHOW_A, then shows 7'h00.
REQ-033 Drop en for 1 cycle during SHOW_A -> an=11 on the next edge; SHOW_A re-entered exactly 2 cycles after en returns, with frame=1.
REQ-034 Assert rst_n=0 asynchronously during SHOW_B -> an=11, seg=7'h7F and sel=0 without waiting for a clock edge.
REQ-035 Set dp_in=2'b10 and val_b=4'hA -> digit 1 shows seg=7'h08 with dp=0; digit 0 shows dp=1; an is never 2'b00 in any cycle.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the two-digit multiplexed 7-segment scanner:
//   - scan_state_t   : scan FSM states, in scan order
//   - SEG_BLANK      : all cathodes off (active-low)
//   - AN_OFF         : both anodes off (active-low)
//   - AN_DIG0/AN_DIG1: anode patterns that light exactly one digit
//   - next_scan_state: successor of a state in the fixed scan cycle
// ----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      SHOW_A  = 2'd0,
      BLANK_A = 2'd1,
      SHOW_B  = 2'd2,
      BLANK_B = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [1:0] AN_OFF    = 2'b11;
   localparam logic [1:0] AN_DIG0   = 2'b10;
   localparam logic [1:0] AN_DIG1   = 2'b01;

   function automatic scan_state_t next_scan_state(input scan_state_t s);
      scan_state_t n;
      case (s)
         SHOW_A:  n = BLANK_A;
         BLANK_A: n = SHOW_B;
         SHOW_B:  n = BLANK_B;
         default: n = SHOW_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg
// Combinational hex digit to 7-segment glyph decoder.
//   hex   in  4  digit value 0..F
//   seg_n out 7  cathodes, active-low, ordered {g,f,e,d,c,b,a}
// Lower-case b and d are used so they are distinguishable from 8 and 0.
// ----------------------------------------------------------------------------
module hex7seg
   import seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (hex)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         4'hF: seg_n = 7'h0E;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Two-digit time-multiplexed 7-segment display scanner with dead time
// between digits to suppress ghosting.
//   Parameters: N (digit width, 4 only), DIV (show dwell, >=2 cycles),
//               BLANK (dead-time dwell, >=1 cycle)
//   clk    in   1  system clock
//   rst_n  in   1  asynchronous active-low reset
//   en     in   1  scan enable; low blanks the display
//   val_a  in   N  digit-0 value
//   val_b  in   N  digit-1 value
//   dp_in  in   2  decimal points (bit0 = digit 0)
//   sel    out  1  digit select for a downstream 2:1 mux (0 = digit 0)
//   an     out  2  anodes, active-low (bit0 = digit 0)
//   seg    out  7  cathodes, active-low {g,f,e,d,c,b,a}
//   dp     out  1  decimal-point cathode, active-low
//   frame  out  1  one-cycle pulse on entry to SHOW_A
// All outputs are registered and are computed from the next state, so they
// change on the same edge as the state register.
// ----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int DIV   = 100000,
   parameter int BLANK = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] val_a,
   input  logic [N-1:0] val_b,
   input  logic [1:0]   dp_in,
   output logic         sel,
   output logic [1:0]   an,
   output logic [6:0]   seg,
   output logic         dp,
   output logic         frame
);

   // Sized from DIV; only widens if BLANK is configured longer than DIV,
   // so the counter can always reach its terminal count without wrapping.
   localparam int DIV_W   = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
   localparam int BLANK_W = ($clog2(BLANK) < 1) ? 1 : $clog2(BLANK);
   localparam int CNT_W   = (BLANK_W > DIV_W) ? BLANK_W : DIV_W;

   localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK - 1);

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     snap_a_q, snap_a_d;
   logic [N-1:0]     snap_b_q, snap_b_d;
   logic [1:0]       snap_dp_q, snap_dp_d;

   logic             sel_q, sel_d;
   logic [1:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_q, frame_d;

   logic             frame_entry;
   logic [6:0]       glyph_a, glyph_b;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BLANK_B;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; a low enable overrides the terminal count and parks
   // the FSM at the start of BLANK_B, so re-enable always costs BLANK cycles.
   always_comb begin
      logic term;
      state_d = state_q;
      cnt_d   = cnt_q;
      term    = 1'b0;
      if ((state_q == SHOW_A) || (state_q == SHOW_B)) begin
         term = (cnt_q == SHOW_TC);
      end else begin
         term = (cnt_q == BLANK_TC);
      end
      if (!en) begin
         state_d = BLANK_B;
         cnt_d   = '0;
      end else if (term) begin
         state_d = next_scan_state(state_q);
         cnt_d   = '0;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   assign frame_entry = (state_d == SHOW_A) && (state_q != SHOW_A);

   // Inputs are captured only at frame start so both digits of a frame
   // come from one coherent sample.
   always_comb begin
      snap_a_d  = snap_a_q;
      snap_b_d  = snap_b_q;
      snap_dp_d = snap_dp_q;
      if (frame_entry) begin
         snap_a_d  = val_a;
         snap_b_d  = val_b;
         snap_dp_d = dp_in;
      end
   end

   // Decoding the next snapshot lets the first SHOW_A cycle already carry
   // the freshly captured digit.
   hex7seg u_dec_a (
      .hex   (snap_a_d[3:0]),
      .seg_n (glyph_a)
   );

   hex7seg u_dec_b (
      .hex   (snap_b_d[3:0]),
      .seg_n (glyph_b)
   );

   // Output logic, driven by the next state
   always_comb begin
      an_d    = AN_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      sel_d   = sel_q;
      frame_d = frame_entry;
      case (state_d)
         SHOW_A: begin
            an_d  = AN_DIG0;
            seg_d = glyph_a;
            dp_d  = ~snap_dp_d[0];
            sel_d = 1'b0;
         end
         SHOW_B: begin
            an_d  = AN_DIG1;
            seg_d = glyph_b;
            dp_d  = ~snap_dp_d[1];
            sel_d = 1'b1;
         end
         default: begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
            sel_d = sel_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_a_q  <= '0;
         snap_b_q  <= '0;
         snap_dp_q <= '0;
         sel_q     <= 1'b0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         snap_a_q  <= snap_a_d;
         snap_b_q  <= snap_b_d;
         snap_dp_q <= snap_dp_d;
         sel_q     <= sel_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         frame_q   <= frame_d;
      end
   end

   assign sel   = sel_q;
   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule
